// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared width and encoding constants for the register file
package regfile_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

    typedef logic [REG_BUS_W-1:0]  reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - write-back and dual read-port bundle of the register file
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port priority mux (bypass under REGFILE_BYPASS_EN)
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] stored,
`ifdef REGFILE_BYPASS_EN
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
`endif
    output logic [DATA_W-1:0] rdata
);

    // reset, then r0, then same-cycle write bypass, then storage, else zero
    always_comb begin
        rdata = '0;
        if (rst == RST_ENABLE) begin
            rdata = '0;
        end else if (raddr == '0) begin
            rdata = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (re == READ_ENABLE && we == WRITE_ENABLE && raddr == waddr) begin
            rdata = wdata;
`endif
        end else if (re == READ_ENABLE) begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, r0 hardwired zero, optional bypass via REGFILE_BYPASS_EN
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int REG_NUM = 2 ** ADDR_W
) (
    input  logic clk,
    input  logic rst,
    regfile_if.slave bus
);

    logic [DATA_W-1:0] regs [REG_NUM];

    // storage: async clear, writes to r0 dropped so it stays zero forever
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.we == WRITE_ENABLE && bus.waddr != '0) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
        .rst    (rst),
        .re     (bus.re1),
        .raddr  (bus.raddr1),
        .stored (regs[bus.raddr1]),
`ifdef REGFILE_BYPASS_EN
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
`endif
        .rdata  (bus.rdata1)
    );

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
        .rst    (rst),
        .re     (bus.re2),
        .raddr  (bus.raddr2),
        .stored (regs[bus.raddr2]),
`ifdef REGFILE_BYPASS_EN
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
`endif
        .rdata  (bus.rdata2)
    );

endmodule
